fb_pattern_writer: RTL

Hardware bus master that fills the 640x480 1-bpp framebuffer of the VGA display block with a selectable pattern: clear, set, checkerboard or inverted checkerboard. It sits on the framebuffer's write port, in place of the CPU-side writer, and issues one 32-bit word write per address. Pixel x+b of a word maps to writedata[b]. It is used for power-on clear and for self-test patterns without software involvement.

---
 rtl/fb_pattern_writer_if.sv | 26 ++
 rtl/fb_pattern_writer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/fb_pattern_writer_if.sv
// Framebuffer write-port bus between the pattern writer (master) and the framebuffer (slave).
interface fb_pattern_writer_if #(
  parameter int unsigned ADDR_W = 15
);
  logic              chipselect;
  logic              write;
  logic [ADDR_W-1:0] address;
  logic [31:0]       writedata;
  logic              waitrequest;

  modport master (
    output chipselect,
    output write,
    output address,
    output writedata,
    input  waitrequest
  );

  modport slave (
    input  chipselect,
    input  write,
    input  address,
    input  writedata,
    output waitrequest
  );
endinterface

// File: rtl/fb_pattern_writer.sv
// Fills a 1-bpp framebuffer with clear/set/checker/inverted-checker, one 32-bit word per address.
module fb_pattern_writer #(
  parameter int unsigned WIDTH        = 640,
  parameter int unsigned HEIGHT       = 480,
  parameter int unsigned CHECKER_SIZE = 20,
  parameter int unsigned ADDR_W       = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          mode,
  fb_pattern_writer_if.master bus,
  output logic                busy,
  output logic                done
);

  localparam int unsigned WORDS_PER_ROW = WIDTH / 32;
  localparam int unsigned LAST_WORD     = (WIDTH * HEIGHT) / 32 - 1;
  localparam int unsigned CNT_W         = $clog2(CHECKER_SIZE + 1);
  localparam int unsigned COL_W         = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BUILD = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] word_q, word_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CNT_W-1:0]  xcnt_q, xcnt_d;
  logic [CNT_W-1:0]  ycnt_q, ycnt_d;
  logic              xph_q, xph_d;
  logic              yph_q, yph_d;
  logic [4:0]        bitcnt_q, bitcnt_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              cs_q, cs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pix_c;
  logic [CNT_W-1:0]  xcnt_inc_c;
  logic [CNT_W-1:0]  ycnt_inc_c;

  // Current checker pixel; inverted checker flips it via mode bit 0
  assign pix_c      = (xph_q ~^ yph_q) ^ mode_q[0];
  assign xcnt_inc_c = xcnt_q + CNT_W'(1);
  assign ycnt_inc_c = ycnt_q + CNT_W'(1);

  // Next-state, counter and registered-output computation
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    word_d   = word_q;
    col_d    = col_q;
    xcnt_d   = xcnt_q;
    ycnt_d   = ycnt_q;
    xph_d    = xph_q;
    yph_d    = yph_q;
    bitcnt_d = bitcnt_q;
    shreg_d  = shreg_q;
    wdata_d  = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d   = mode;
          word_d   = '0;
          col_d    = '0;
          xcnt_d   = '0;
          ycnt_d   = '0;
          xph_d    = 1'b0;
          yph_d    = 1'b0;
          bitcnt_d = '0;
          if (mode[1]) begin
            state_d = S_BUILD;
          end else begin
            state_d = S_WRITE;
            wdata_d = {32{mode[0]}};
          end
        end
      end

      S_BUILD: begin
        // Pixel b lands in bit b after 32 right shifts
        shreg_d  = {pix_c, shreg_q[31:1]};
        bitcnt_d = bitcnt_q + 5'd1;
        if (xcnt_inc_c == CNT_W'(CHECKER_SIZE)) begin
          xcnt_d = '0;
          xph_d  = ~xph_q;
        end else begin
          xcnt_d = xcnt_inc_c;
        end
        if (bitcnt_q == 5'd31) begin
          state_d = S_WRITE;
          wdata_d = shreg_d;
        end
      end

      S_WRITE: begin
        if (!bus.waitrequest) begin
          if (word_q == ADDR_W'(LAST_WORD)) begin
            state_d = S_DONE;
          end else begin
            word_d  = word_q + ADDR_W'(1);
            state_d = mode_q[1] ? S_BUILD : S_WRITE;
            if (col_q == COL_W'(WORDS_PER_ROW - 1)) begin
              col_d  = '0;
              xcnt_d = '0;
              xph_d  = 1'b0;
              if (ycnt_inc_c == CNT_W'(CHECKER_SIZE)) begin
                ycnt_d = '0;
                yph_d  = ~yph_q;
              end else begin
                ycnt_d = ycnt_inc_c;
              end
            end else begin
              col_d = col_q + COL_W'(1);
            end
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    cs_d   = (state_d == S_WRITE);
    busy_d = (state_d == S_BUILD) || (state_d == S_WRITE);
    done_d = (state_d == S_DONE);
  end

  // State, counters and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= 2'd0;
      word_q   <= '0;
      col_q    <= '0;
      xcnt_q   <= '0;
      ycnt_q   <= '0;
      xph_q    <= 1'b0;
      yph_q    <= 1'b0;
      bitcnt_q <= '0;
      shreg_q  <= '0;
      wdata_q  <= '0;
      cs_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      word_q   <= word_d;
      col_q    <= col_d;
      xcnt_q   <= xcnt_d;
      ycnt_q   <= ycnt_d;
      xph_q    <= xph_d;
      yph_q    <= yph_d;
      bitcnt_q <= bitcnt_d;
      shreg_q  <= shreg_d;
      wdata_q  <= wdata_d;
      cs_q     <= cs_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.chipselect = cs_q;
  assign bus.write      = cs_q;
  assign bus.address    = word_q;
  assign bus.writedata  = wdata_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
